// File: rtl/atm_pkg.sv
// Shared codes, widths and state encoding for the ATM session controller.
package atm_pkg;

  localparam int unsigned ACCT_W    = 4;
  localparam int unsigned PIN_W     = 16;
  localparam int unsigned AMT_W     = 10;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned RES_W     = 2;
  localparam int unsigned NUM_ACCTS = 16;

  typedef enum logic [SEL_W-1:0] {
    SEL_INVENTORY = 2'b00,
    SEL_WITHDRAW  = 2'b01,
    SEL_TRANSFER  = 2'b10,
    SEL_EXIT      = 2'b11
  } op_sel_e;

  localparam logic [RES_W-1:0] RES_FAIL = 2'b00;
  localparam logic [RES_W-1:0] RES_OK   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIN_WAIT,
    ST_MENU,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_REPORT,
    ST_EJECT
  } state_e;

endpackage

// File: rtl/atm_pin_rom.sv
// Combinational PIN table: account n holds the BCD digits of 1000+n.
module atm_pin_rom
  import atm_pkg::*;
(
  input  logic [ACCT_W-1:0] acct,
  output logic [PIN_W-1:0]  pin
);

  always_comb begin
    if (acct < 4'd10) begin
      pin = {4'h1, 4'h0, 4'h0, acct};
    end else begin
      pin = {4'h1, 4'h0, 4'h1, acct - 4'd10};
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN admission, menu operations, downstream
// request/response handshake, idle timeout and sticky per-account lockout.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_valid,
  input  logic [ACCT_W-1:0] card_acct,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin_code,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [SEL_W-1:0]  op_sel,
  input  logic [ACCT_W-1:0] op_dest,
  input  logic [AMT_W-1:0]  op_amount,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [SEL_W-1:0]  req_select,
  output logic [ACCT_W-1:0] req_origin,
  output logic [ACCT_W-1:0] req_purpose,
  output logic [AMT_W-1:0]  req_amount,
  input  logic              rsp_valid,
  input  logic [RES_W-1:0]  rsp_result,
  input  logic [AMT_W-1:0]  rsp_inventory,
  output logic              done_valid,
  output logic [RES_W-1:0]  done_result,
  output logic [AMT_W-1:0]  done_inventory,
  output logic              session_active,
  output logic              eject
);

  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  localparam int unsigned TRY_W =
    ($clog2(MAX_TRIES + 1) > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_LAST     = TRY_W'(MAX_TRIES - 1);

  state_e                 state_q, state_d;
  logic [ACCT_W-1:0]      acct_q, acct_d;
  logic [TRY_W-1:0]       tries_q, tries_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [NUM_ACCTS-1:0]   lock_q, lock_d;
  op_sel_e                sel_q, sel_d;
  logic [ACCT_W-1:0]      dest_q, dest_d;
  logic [AMT_W-1:0]       amount_q, amount_d;
  logic [RES_W-1:0]       done_result_q, done_result_d;
  logic [AMT_W-1:0]       done_inventory_q, done_inventory_d;
  logic [PIN_W-1:0]       rom_pin;
  op_sel_e                op_sel_in;

  atm_pin_rom u_pin_rom (
    .acct (acct_q),
    .pin  (rom_pin)
  );

  assign op_sel_in = op_sel_e'(op_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      acct_q           <= '0;
      tries_q          <= '0;
      idle_cnt_q       <= '0;
      lock_q           <= '0;
      sel_q            <= SEL_INVENTORY;
      dest_q           <= '0;
      amount_q         <= '0;
      done_result_q    <= '0;
      done_inventory_q <= '0;
    end else begin
      state_q          <= state_d;
      acct_q           <= acct_d;
      tries_q          <= tries_d;
      idle_cnt_q       <= idle_cnt_d;
      lock_q           <= lock_d;
      sel_q            <= sel_d;
      dest_q           <= dest_d;
      amount_q         <= amount_d;
      done_result_q    <= done_result_d;
      done_inventory_q <= done_inventory_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    acct_d           = acct_q;
    tries_d          = tries_q;
    idle_cnt_d       = idle_cnt_q;
    lock_d           = lock_q;
    sel_d            = sel_q;
    dest_d           = dest_q;
    amount_d         = amount_q;
    done_result_d    = done_result_q;
    done_inventory_d = done_inventory_q;

    case (state_q)
      ST_IDLE: begin
        if (card_valid) begin
          acct_d = card_acct;
          if (lock_q[card_acct]) begin
            state_d          = ST_EJECT;
            done_result_d    = RES_FAIL;
            done_inventory_d = '0;
          end else begin
            state_d = ST_PIN_WAIT;
            tries_d = '0;
          end
        end
      end

      ST_PIN_WAIT: begin
        if (pin_valid) begin
          idle_cnt_d = '0;
          if (pin_code == rom_pin) begin
            state_d = ST_MENU;
          end else if (tries_q >= TRY_LAST) begin
            lock_d[acct_q]   = 1'b1;
            state_d          = ST_EJECT;
            done_result_d    = RES_FAIL;
            done_inventory_d = '0;
          end else begin
            tries_d = tries_q + TRY_W'(1);
          end
        end else if (idle_cnt_q == TIMEOUT_LAST) begin
          state_d          = ST_EJECT;
          done_result_d    = RES_FAIL;
          done_inventory_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      ST_MENU: begin
        if (op_valid) begin
          idle_cnt_d = '0;
          sel_d      = op_sel_in;
          dest_d     = op_dest;
          amount_d   = op_amount;
          if (op_sel_in == SEL_EXIT) begin
            state_d          = ST_EJECT;
            done_result_d    = RES_OK;
            done_inventory_d = '0;
          end else if ((op_sel_in != SEL_INVENTORY && op_amount == '0) ||
                       (op_sel_in == SEL_TRANSFER && op_dest == acct_q)) begin
            // Rejected locally; the core never sees it.
            state_d          = ST_REPORT;
            done_result_d    = RES_FAIL;
            done_inventory_d = '0;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (idle_cnt_q == TIMEOUT_LAST) begin
          state_d          = ST_EJECT;
          done_result_d    = RES_FAIL;
          done_inventory_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      ST_ISSUE: begin
        if (req_ready) begin
          state_d = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          state_d          = ST_REPORT;
          done_result_d    = rsp_result;
          done_inventory_d = rsp_inventory;
        end
      end

      ST_REPORT: state_d = ST_MENU;
      ST_EJECT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      idle_cnt_d = '0;
    end
  end

  // Every route into EJECT carries an outcome, so done_valid covers both.
  assign op_ready       = (state_q == ST_MENU);
  assign req_valid      = (state_q == ST_ISSUE);
  assign req_select     = sel_q;
  assign req_origin     = acct_q;
  assign req_purpose    = (sel_q == SEL_TRANSFER) ? dest_q : acct_q;
  assign req_amount     = (sel_q == SEL_INVENTORY) ? '0 : amount_q;
  assign done_valid     = (state_q == ST_REPORT) || (state_q == ST_EJECT);
  assign done_result    = done_result_q;
  assign done_inventory = done_inventory_q;
  assign eject          = (state_q == ST_EJECT);
  assign session_active = (state_q != ST_IDLE) && (state_q != ST_EJECT);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios plus randomized sessions
// checked against a transaction-level model of accounts, PINs and locks.
module tb_atm_session_ctrl;

  localparam int unsigned MAX_TRIES      = 3;
  localparam int unsigned TIMEOUT_CYCLES = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        card_valid = 1'b0;
  logic [3:0]  card_acct = '0;
  logic        pin_valid = 1'b0;
  logic [15:0] pin_code = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_sel = '0;
  logic [3:0]  op_dest = '0;
  logic [9:0]  op_amount = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [1:0]  req_select;
  logic [3:0]  req_origin;
  logic [3:0]  req_purpose;
  logic [9:0]  req_amount;
  logic        rsp_valid = 1'b0;
  logic [1:0]  rsp_result = '0;
  logic [9:0]  rsp_inventory = '0;
  logic        done_valid;
  logic [1:0]  done_result;
  logic [9:0]  done_inventory;
  logic        session_active;
  logic        eject;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .MAX_TRIES      (MAX_TRIES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .card_valid     (card_valid),
    .card_acct      (card_acct),
    .pin_valid      (pin_valid),
    .pin_code       (pin_code),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_sel         (op_sel),
    .op_dest        (op_dest),
    .op_amount      (op_amount),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_select     (req_select),
    .req_origin     (req_origin),
    .req_purpose    (req_purpose),
    .req_amount     (req_amount),
    .rsp_valid      (rsp_valid),
    .rsp_result     (rsp_result),
    .rsp_inventory  (rsp_inventory),
    .done_valid     (done_valid),
    .done_result    (done_result),
    .done_inventory (done_inventory),
    .session_active (session_active),
    .eject          (eject)
  );

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int reqv_cycles = 0;

  always @(posedge clk) begin
    if (req_valid && req_ready) hs_count++;
    if (req_valid) reqv_cycles++;
  end

  // Model state
  bit locked [16];
  int cur_acct;
  int tries;

  function automatic logic [15:0] pin_of(input int n);
    int v;
    v = 1000 + n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [63:0] all_outs();
    return {27'd0, op_ready, req_valid, req_select, req_origin, req_purpose,
            req_amount, done_valid, done_result, done_inventory,
            session_active, eject};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic insert_card(input int acct, output bit admitted);
    card_valid = 1'b1;
    card_acct  = 4'(acct);
    tick();
    card_valid = 1'b0;
    cur_acct   = acct;
    tries      = 0;
    if (locked[acct]) begin
      chk("locked_card_eject", {done_valid, done_result, eject}, {1'b1, 2'b00, 1'b1});
      tick();
      chk("locked_card_idle", {session_active, eject, done_valid}, 3'b000);
      admitted = 1'b0;
    end else begin
      chk("card_admitted", {session_active, eject, op_ready}, 3'b100);
      admitted = 1'b1;
    end
  endtask

  task automatic enter_pin(input logic [15:0] code, input bit with_op, output bit in_menu);
    int hs0;
    hs0 = hs_count;
    pin_valid = 1'b1;
    pin_code  = code;
    if (with_op) begin
      op_valid = 1'b1;
      op_sel   = 2'b11;
    end
    tick();
    pin_valid = 1'b0;
    op_valid  = 1'b0;
    in_menu   = 1'b0;
    if (code == pin_of(cur_acct)) begin
      chk("pin_ok_menu", {op_ready, session_active, eject}, 3'b110);
      in_menu = 1'b1;
    end else begin
      tries++;
      if (tries >= MAX_TRIES) begin
        locked[cur_acct] = 1'b1;
        chk("pin_lockout", {done_valid, done_result, eject}, {1'b1, 2'b00, 1'b1});
        tick();
        chk("pin_lockout_idle", {session_active, eject}, 2'b00);
      end else begin
        chk("pin_retry", {session_active, op_ready, eject, done_valid}, 4'b1000);
      end
    end
    chk("pin_no_req", hs_count - hs0, 0);
  endtask

  task automatic do_op(input logic [1:0] sel, input logic [3:0] dest, input logic [9:0] amt,
                       input logic [1:0] res, input logic [9:0] inv, input int delay,
                       input bit with_pin, output bit ended);
    int hs0, rv0;
    logic [19:0] exp_req;
    hs0 = hs_count;
    rv0 = reqv_cycles;
    ended = 1'b0;
    op_valid  = 1'b1;
    op_sel    = sel;
    op_dest   = dest;
    op_amount = amt;
    if (with_pin) begin
      pin_valid = 1'b1;
      pin_code  = 16'h9999;
    end
    tick();
    op_valid  = 1'b0;
    pin_valid = 1'b0;
    if (sel == 2'b11) begin
      chk("exit_done", {done_valid, done_result, eject}, {1'b1, 2'b01, 1'b1});
      tick();
      chk("exit_idle", {session_active, eject, done_valid}, 3'b000);
      ended = 1'b1;
    end else if (((sel == 2'b01 || sel == 2'b10) && amt == 0) ||
                 (sel == 2'b10 && int'(dest) == cur_acct)) begin
      chk("short_done", {done_valid, done_result, req_valid, eject}, {1'b1, 2'b00, 1'b0, 1'b0});
      tick();
      chk("short_menu", {op_ready, done_valid}, 2'b10);
      chk("short_no_req", reqv_cycles - rv0, 0);
    end else begin
      exp_req = {sel, 4'(cur_acct), (sel == 2'b10) ? dest : 4'(cur_acct),
                 (sel == 2'b00) ? 10'd0 : amt};
      chk("req_valid", {req_valid, op_ready}, 2'b10);
      chk("req_fields", {req_select, req_origin, req_purpose, req_amount}, exp_req);
      repeat (delay) tick();
      chk("req_hold_valid", req_valid, 1'b1);
      chk("req_hold_fields", {req_select, req_origin, req_purpose, req_amount}, exp_req);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk("req_after_hs", req_valid, 1'b0);
      chk("single_req", hs_count - hs0, 1);
      repeat ($urandom_range(0, 3)) tick();
      chk("wait_no_done", {done_valid, op_ready}, 2'b00);
      rsp_valid     = 1'b1;
      rsp_result    = res;
      rsp_inventory = inv;
      tick();
      rsp_valid = 1'b0;
      chk("rsp_done", {done_valid, done_result, done_inventory}, {1'b1, res, inv});
      tick();
      chk("back_menu", {op_ready, done_valid}, 2'b10);
      chk("done_held", {done_result, done_inventory}, {res, inv});
    end
  endtask

  initial begin
    bit ok, menu, ended;
    int acct, nwrong, nops;
    logic [1:0] sel;
    logic [3:0] dest;
    logic [9:0] amt;

    // Reset
    #1 rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", all_outs(), 64'd0);

    // Card 3 inventory enquiry, core returns OK / 0x0D6
    insert_card(3, ok);
    enter_pin(16'h1003, 1'b0, menu);
    do_op(2'b00, 4'd0, 10'd5, 2'b01, 10'h0D6, 0, 1'b0, ended);
    do_op(2'b11, 4'd0, 10'd0, 2'b00, 10'd0, 0, 1'b0, ended);

    // Card 5: three wrong PINs lock it; reinsertion ejects at once
    insert_card(5, ok);
    enter_pin(16'h1004, 1'b0, menu);
    enter_pin(16'h0000, 1'b1, menu);
    enter_pin(16'h1050, 1'b0, menu);
    insert_card(5, ok);

    // Local rejects and inputs ignored in MENU
    insert_card(2, ok);
    enter_pin(16'h1002, 1'b0, menu);
    do_op(2'b01, 4'd0, 10'd0, 2'b00, 10'd0, 0, 1'b0, ended);
    do_op(2'b10, 4'd2, 10'd40, 2'b00, 10'd0, 0, 1'b0, ended);
    rsp_valid  = 1'b1;
    rsp_result = 2'b01;
    card_valid = 1'b1;
    card_acct  = 4'd7;
    tick();
    rsp_valid  = 1'b0;
    card_valid = 1'b0;
    chk("menu_ignores_rsp_card", {op_ready, done_valid, eject, req_valid}, 4'b1000);

    // Back-pressured transfer: fields must hold for 10 cycles
    do_op(2'b10, 4'd7, 10'd100, 2'b01, 10'd50, 10, 1'b0, ended);
    do_op(2'b11, 4'd0, 10'd0, 2'b00, 10'd0, 0, 1'b0, ended);

    // PIN_WAIT timeout fires exactly at the limit
    insert_card(9, ok);
    repeat (TIMEOUT_CYCLES - 1) tick();
    chk("timeout_not_yet", {session_active, eject}, 2'b10);
    tick();
    chk("timeout_eject", {done_valid, done_result, eject}, {1'b1, 2'b00, 1'b1});
    tick();
    chk("timeout_idle", {session_active, eject}, 2'b00);

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      acct = int'($urandom_range(0, 15));
      insert_card(acct, ok);
      if (!ok) continue;
      nwrong = int'($urandom_range(0, 3));
      menu = 1'b0;
      for (int w = 0; w < nwrong; w++) begin
        enter_pin(pin_of(acct) ^ (16'h1 << $urandom_range(0, 15)), 1'($urandom_range(0, 1)), menu);
        if (locked[acct]) break;
      end
      if (locked[acct]) continue;
      enter_pin(pin_of(acct), 1'($urandom_range(0, 1)), menu);
      nops = int'($urandom_range(1, 4));
      ended = 1'b0;
      for (int k = 0; k < nops && !ended; k++) begin
        sel  = 2'($urandom_range(0, 3));
        dest = ($urandom_range(0, 3) == 0) ? 4'(acct) : 4'($urandom_range(0, 15));
        amt  = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        do_op(sel, dest, amt, 2'($urandom_range(0, 1)), 10'($urandom),
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), ended);
      end
      if (!ended) do_op(2'b11, 4'd0, 10'd0, 2'b00, 10'd0, 0, 1'b0, ended);
    end

    // Reset while waiting for a core response
    insert_card(4, ok);
    enter_pin(16'h1004, 1'b0, menu);
    op_valid  = 1'b1;
    op_sel    = 2'b01;
    op_dest   = 4'd0;
    op_amount = 10'd9;
    tick();
    op_valid  = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("pre_reset_wait_rsp", {req_valid, session_active}, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) locked[i] = 1'b0;
    tick();
    chk("post_reset_idle", all_outs(), 64'd0);
    insert_card(5, ok);
    chk("lock_cleared", ok, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 Parameter MAX_TRIES, 3, wrong-PIN attempts before account lock.
REQ-002 Parameter TIMEOUT_CYCLES, 1000, idle cycles in PIN_WAIT/MENU before forced eject.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 card_valid  in  1  one-cycle pulse: card inserted.
REQ-006 card_acct  in  4  account number on card, sampled with card_valid.
REQ-007 pin_valid  in  1  one-cycle pulse: PIN entered.
REQ-008 pin_code  in  16  four BCD digits, sampled with pin_valid.
REQ-009 op_valid  in  1  user operation request.
REQ-010 op_ready  out  1  operation accepted when op_valid&&op_ready.
REQ-011 op_sel  in  2  00 inventory, 01 withdraw, 10 deposit/transfer, 11 exit.
REQ-012 op_dest  in  4  purpose account for 10.
REQ-013 op_amount  in  10  amount for 01/10.
REQ-014 req_valid  out  1  request to downstream ATM core.
REQ-015 req_ready  in  1  core accepts when req_valid&&req_ready.
REQ-016 req_select / req_origin / req_purpose / req_amount  out  2/4/4/10  request fields, stable while req_valid.
REQ-017 rsp_valid  in  1  one-cycle pulse: core result available.
REQ-018 rsp_result / rsp_inventory  in  2/10  core result (01 ok, 00 fail) and balance.
REQ-019 done_valid  out  1  one-cycle pulse: operation outcome to user.
REQ-020 done_result / done_inventory  out  2/10  outcome, held until next done_valid.
REQ-021 session_active  out  1  high in PIN_WAIT..REPORT.
REQ-022 eject  out  1  one-cycle pulse: card returned.

Function
REQ-023 States: IDLE, PIN_WAIT, MENU, ISSUE, WAIT_RSP, REPORT, EJECT.
REQ-024 IDLE: card_valid latches card_acct; locked account -> EJECT with done_valid, done_result=00; else -> PIN_WAIT, try counter cleared.
REQ-025 PIN_WAIT: pin_valid compared to atm_pin_rom[acct]; match -> MENU; mismatch increments tries; tries reaching MAX_TRIES sets lock bit for acct, done_result=00, -> EJECT.
REQ-026 MENU: op_ready=1 only here; accepted op 11 -> EJECT, done_result=01; op 01/10 with op_amount==0, or op 10 with op_dest==acct -> REPORT, done_result=00, no downstream request; otherwise -> ISSUE.
REQ-027 ISSUE: req_valid=1, fields from latched op and acct (req_purpose=acct for 00/01); -> WAIT_RSP on handshake same cycle; no field change while waiting.
REQ-028 WAIT_RSP: rsp_valid latches rsp_result/rsp_inventory -> REPORT; rsp_valid outside WAIT_RSP ignored.
REQ-029 REPORT: done_valid for exactly one cycle -> MENU.
REQ-030 EJECT: eject for one cycle -> IDLE; card_valid outside IDLE ignored.
REQ-031 Idle counter 10 bits+, cleared on any accepted pin/op and on state entry; reaching TIMEOUT_CYCLES in PIN_WAIT or MENU -> EJECT, done_result=00; no timeout in ISSUE/WAIT_RSP.
REQ-032 pin_valid and op_valid in same cycle: only the input relevant to current state acts.
REQ-033 Lock bitmap 16 bits, sticky until reset; reset clears it.

Reset
REQ-034 rst asserted: state IDLE, all outputs 0, counters, tries, latches and lock bitmap 0, effective immediately, including mid-transaction (outstanding request abandoned).

Structure
REQ-035 Shared package atm_pkg: select codes, result codes (OK=01, FAIL=00), state enum, field widths.
REQ-036 Sub-module atm_pin_rom: combinational 16x16 PIN table indexed by account; entry n = BCD of 1000+n.

Verification
REQ-037 Card 3, PIN 1003, op 00, core rsp 01/0x0D6 -> one req (sel 00, origin 3), done 01/0x0D6, back to MENU.
REQ-038 Card 5, PIN wrong x3 -> done 00, eject pulse; reinsert card 5 -> immediate eject, done 00.
REQ-039 MENU, op 01 amount 0 -> done 00, req_valid never asserted.
REQ-040 ISSUE with req_ready low 10 cycles -> req fields stable, then handshake, single request.
REQ-041 PIN_WAIT idle TIMEOUT_CYCLES -> eject exactly at limit; rst during WAIT_RSP -> all outputs 0 next edge-free cycle, IDLE.
